// File: rtl/hazard_scoreboard_unit.sv
// Decode-side hazard unit: a per-register latency scoreboard stalls dependents of
// variable-latency producers, holds a multi-cycle flush after redirects, freezes on dmem.
module hazard_scoreboard_unit #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned NUM_RD      = 2,
  parameter int unsigned MAX_LAT     = 4,
  parameter int unsigned CNT_W       = 3,
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int unsigned PERF_W      = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         id_valid,
  input  logic [NUM_RD*REG_ADDR_W-1:0] id_rsel,
  input  logic [NUM_RD-1:0]            id_ruse,
  input  logic [REG_ADDR_W-1:0]        id_wsel,
  input  logic                         id_wen,
  input  logic [CNT_W-1:0]             id_lat,
  input  logic [1:0]                   pc_src,
  input  logic                         dmem_busy,
  output logic                         pc_en,
  output logic                         id_en,
  output logic                         flushed,
  output logic                         ex_bubble,
  output logic                         issue,
  output logic [PERF_W-1:0]            stall_cnt,
  output logic [PERF_W-1:0]            flush_cnt
);

  localparam int unsigned NumRegs = 2 ** REG_ADDR_W;
  localparam int unsigned FlW     = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
  localparam logic [CNT_W-1:0] MaxLat   = CNT_W'(MAX_LAT);
  localparam logic [FlW-1:0]   FlReload = FlW'(FLUSH_DEPTH - 1);

  logic [CNT_W-1:0]      sb_cnt_q [NumRegs];
  logic [CNT_W-1:0]      sb_cnt_d [NumRegs];
  logic [FlW-1:0]        fl_cnt_q, fl_cnt_d;
  logic [PERF_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic                  freeze, redirect, flush_act, dstall;
  logic [REG_ADDR_W-1:0] rd_idx;

  assign freeze    = dmem_busy;
  assign redirect  = (pc_src != 2'd0);
  assign flush_act = redirect || (fl_cnt_q != '0);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  always_comb begin
    dstall = 1'b0;
    rd_idx = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_idx = id_rsel[i*REG_ADDR_W +: REG_ADDR_W];
      if (id_valid && id_ruse[i] && (rd_idx != '0) && (sb_cnt_q[rd_idx] != '0)) begin
        dstall = 1'b1;
      end
    end
  end

  // Priority: reset, freeze, flush, data stall, normal.
  always_comb begin
    pc_en     = 1'b1;
    id_en     = 1'b1;
    flushed   = 1'b0;
    ex_bubble = 1'b0;
    issue     = 1'b0;
    if (RST) begin
      pc_en     = 1'b0;
      id_en     = 1'b0;
      flushed   = 1'b1;
      ex_bubble = 1'b1;
    end else if (freeze) begin
      pc_en = 1'b0;
      id_en = 1'b0;
    end else if (flush_act) begin
      flushed   = 1'b1;
      ex_bubble = 1'b1;
    end else if (dstall) begin
      pc_en     = 1'b0;
      id_en     = 1'b0;
      ex_bubble = 1'b1;
    end else begin
      issue = id_valid;
    end
  end

  always_comb begin
    sb_cnt_d    = sb_cnt_q;
    fl_cnt_d    = fl_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!freeze) begin
      for (int r = 1; r < NumRegs; r++) begin
        if (sb_cnt_q[r] != '0) sb_cnt_d[r] = sb_cnt_q[r] - CNT_W'(1);
      end
      // Issue write lands after the decrement so it overrides the same entry.
      if (issue && id_wen && (id_wsel != '0)) begin
        sb_cnt_d[id_wsel] = (id_lat > MaxLat) ? MaxLat : id_lat;
      end
      if (flush_act) begin
        fl_cnt_d = redirect ? FlReload : fl_cnt_q - FlW'(1);
        if (flush_cnt_q != {PERF_W{1'b1}}) flush_cnt_d = flush_cnt_q + PERF_W'(1);
      end else if (dstall) begin
        if (stall_cnt_q != {PERF_W{1'b1}}) stall_cnt_d = stall_cnt_q + PERF_W'(1);
      end
    end
    sb_cnt_d[0] = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < NumRegs; r++) sb_cnt_q[r] <= '0;
      fl_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NumRegs; r++) sb_cnt_q[r] <= sb_cnt_d[r];
      fl_cnt_q    <= fl_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: per-cycle vector table plus hand-written
// reset-mid-stall and counter-saturation sequences.
module tb_hazard_scoreboard_unit;

  localparam logic [4:0] NormI = 5'b11001;  // {pc_en,id_en,flushed,ex_bubble,issue}
  localparam logic [4:0] NormN = 5'b11000;
  localparam logic [4:0] Stall = 5'b00010;
  localparam logic [4:0] Flush = 5'b11110;
  localparam logic [4:0] Frz   = 5'b00000;
  localparam logic [4:0] RstO  = 5'b00110;

  typedef struct {
    logic       valid;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] ruse;
    logic [4:0] ws;
    logic       wen;
    logic [2:0] lat;
    logic [1:0] pcs;
    logic       busy;
    logic [4:0] exp;
    int         stall;
    int         flush;
  } vec_t;

  logic        CLK, RST, id_valid, id_wen, dmem_busy;
  logic [9:0]  id_rsel;
  logic [1:0]  id_ruse, pc_src;
  logic [4:0]  id_wsel;
  logic [2:0]  id_lat;
  logic        pc_en, id_en, flushed, ex_bubble, issue;
  logic [15:0] stall_cnt, flush_cnt;
  logic        pc_en_s, id_en_s, flushed_s, ex_bubble_s, issue_s;
  logic [2:0]  stall_cnt_s, flush_cnt_s;

  int tests = 0;
  int fails = 0;
  vec_t vecs[$];

  hazard_scoreboard_unit #(.FLUSH_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rsel(id_rsel), .id_ruse(id_ruse),
    .id_wsel(id_wsel), .id_wen(id_wen), .id_lat(id_lat), .pc_src(pc_src),
    .dmem_busy(dmem_busy), .pc_en(pc_en), .id_en(id_en), .flushed(flushed),
    .ex_bubble(ex_bubble), .issue(issue), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_scoreboard_unit #(.PERF_W(3)) dut_sat (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rsel(id_rsel), .id_ruse(id_ruse),
    .id_wsel(id_wsel), .id_wen(id_wen), .id_lat(id_lat), .pc_src(pc_src),
    .dmem_busy(dmem_busy), .pc_en(pc_en_s), .id_en(id_en_s), .flushed(flushed_s),
    .ex_bubble(ex_bubble_s), .issue(issue_s), .stall_cnt(stall_cnt_s),
    .flush_cnt(flush_cnt_s)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                              input logic [1:0] ru, input logic [4:0] ws, input logic we,
                              input logic [2:0] lt, input logic [1:0] pcs, input logic bz,
                              input logic [4:0] ex, input int st, input int fl);
    vec_t t;
    t.valid = v; t.rs0 = rs0; t.rs1 = rs1; t.ruse = ru; t.ws = ws; t.wen = we;
    t.lat = lt; t.pcs = pcs; t.busy = bz; t.exp = ex; t.stall = st; t.flush = fl;
    return t;
  endfunction

  task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] ru, input logic [4:0] ws, input logic we,
                       input logic [2:0] lt, input logic [1:0] pcs, input logic bz);
    id_valid = v; id_rsel = {rs1, rs0}; id_ruse = ru; id_wsel = ws; id_wen = we;
    id_lat = lt; pc_src = pcs; dmem_busy = bz;
  endtask

  task automatic check_out(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {pc_en, id_en, flushed, ex_bubble, issue};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: {pc_en,id_en,flushed,ex_bubble,issue} got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic [4:0] rs0, input logic [1:0] ru,
                       input logic [4:0] ws, input logic we, input logic [2:0] lt,
                       input logic [1:0] pcs);
    @(posedge CLK);
    #1;
    drive(v, rs0, 5'd0, ru, ws, we, lt, pcs, 1'b0);
  endtask

  initial begin
    // Load-use
    vecs.push_back(mk(1, 0, 0, 2'b00, 5, 1, 1, 0, 0, NormI, 0, 0));
    vecs.push_back(mk(1, 5, 0, 2'b01, 0, 0, 0, 0, 0, Stall, 0, 0));
    vecs.push_back(mk(1, 5, 0, 2'b01, 0, 0, 0, 0, 0, NormI, 1, 0));
    // Long latency with freeze in the middle
    vecs.push_back(mk(1, 0, 0, 2'b00, 7, 1, 3, 0, 0, NormI, 1, 0));
    vecs.push_back(mk(1, 7, 0, 2'b01, 0, 0, 0, 0, 0, Stall, 1, 0));
    vecs.push_back(mk(1, 7, 0, 2'b01, 0, 0, 0, 0, 1, Frz,   2, 0));
    vecs.push_back(mk(1, 7, 0, 2'b01, 0, 0, 0, 0, 1, Frz,   2, 0));
    vecs.push_back(mk(1, 7, 0, 2'b01, 0, 0, 0, 0, 0, Stall, 2, 0));
    vecs.push_back(mk(1, 7, 0, 2'b01, 0, 0, 0, 0, 0, Stall, 3, 0));
    vecs.push_back(mk(1, 7, 0, 2'b01, 0, 0, 0, 0, 0, NormI, 4, 0));
    // Register 0 and unused operand
    vecs.push_back(mk(1, 0, 0, 2'b00, 0, 1, 4, 0, 0, NormI, 4, 0));
    vecs.push_back(mk(1, 0, 0, 2'b01, 0, 0, 0, 0, 0, NormI, 4, 0));
    vecs.push_back(mk(1, 0, 0, 2'b00, 3, 1, 2, 0, 0, NormI, 4, 0));
    vecs.push_back(mk(1, 0, 3, 2'b01, 0, 0, 0, 0, 0, NormI, 4, 0));
    vecs.push_back(mk(1, 0, 3, 2'b10, 0, 0, 0, 0, 0, Stall, 4, 0));
    vecs.push_back(mk(1, 0, 3, 2'b10, 0, 0, 0, 0, 0, NormI, 5, 0));
    // Redirect, FLUSH_DEPTH=2, then an extending second redirect
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 2, 0, Flush, 5, 0));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, Flush, 5, 1));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, NormN, 5, 2));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 2, 0, Flush, 5, 2));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 3, 0, Flush, 5, 3));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, Flush, 5, 4));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, NormN, 5, 5));
    // Redirect beats data stall; squashed writer of r11 must not mark it
    vecs.push_back(mk(1, 0, 0, 2'b00, 9, 1, 2, 0, 0, NormI, 5, 5));
    vecs.push_back(mk(1, 9, 0, 2'b01, 11, 1, 4, 1, 0, Flush, 5, 5));
    vecs.push_back(mk(1, 11, 0, 2'b01, 0, 0, 0, 0, 0, Flush, 5, 6));
    vecs.push_back(mk(1, 11, 0, 2'b01, 0, 0, 0, 0, 0, NormI, 5, 7));
    // Redirect during freeze is deferred
    vecs.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 1, 1, Frz,   5, 7));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, Flush, 5, 7));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, Flush, 5, 8));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, NormN, 5, 9));
    // Latency clamped to MAX_LAT=4
    vecs.push_back(mk(1, 0, 0, 2'b00, 12, 1, 7, 0, 0, NormI, 5, 9));
    vecs.push_back(mk(1, 12, 0, 2'b01, 0, 0, 0, 0, 0, Stall, 5, 9));
    vecs.push_back(mk(1, 12, 0, 2'b01, 0, 0, 0, 0, 0, Stall, 6, 9));
    vecs.push_back(mk(1, 12, 0, 2'b01, 0, 0, 0, 0, 0, Stall, 7, 9));
    vecs.push_back(mk(1, 12, 0, 2'b01, 0, 0, 0, 0, 0, Stall, 8, 9));
    vecs.push_back(mk(1, 12, 0, 2'b01, 0, 0, 0, 0, 0, NormI, 9, 9));
    // Zero latency, and no stall without id_valid
    vecs.push_back(mk(1, 0, 0, 2'b00, 13, 1, 0, 0, 0, NormI, 9, 9));
    vecs.push_back(mk(1, 13, 0, 2'b01, 0, 0, 0, 0, 0, NormI, 9, 9));
    vecs.push_back(mk(1, 0, 0, 2'b00, 14, 1, 2, 0, 0, NormI, 9, 9));
    vecs.push_back(mk(0, 14, 0, 2'b01, 0, 0, 0, 0, 0, NormN, 9, 9));
    vecs.push_back(mk(1, 14, 0, 2'b01, 0, 0, 0, 0, 0, Stall, 9, 9));
    vecs.push_back(mk(1, 14, 0, 2'b01, 0, 0, 0, 0, 0, NormI, 10, 9));

    RST = 1'b1;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    #2;
    check_out("reset_outputs", RstO);
    @(negedge CLK);
    check_val("reset_stall_cnt", int'(stall_cnt), 0);
    check_val("reset_flush_cnt", int'(flush_cnt), 0);

    foreach (vecs[k]) begin
      @(posedge CLK);
      #1;
      RST = 1'b0;
      drive(vecs[k].valid, vecs[k].rs0, vecs[k].rs1, vecs[k].ruse, vecs[k].ws, vecs[k].wen,
            vecs[k].lat, vecs[k].pcs, vecs[k].busy);
      @(negedge CLK);
      check_out($sformatf("vec%0d_ctrl", k), vecs[k].exp);
      check_val($sformatf("vec%0d_stall_cnt", k), int'(stall_cnt), vecs[k].stall);
      check_val($sformatf("vec%0d_flush_cnt", k), int'(flush_cnt), vecs[k].flush);
    end

    // Reset while r9 is pending (3) and the flush window is open
    cycle(1, 0, 2'b00, 9, 1, 4, 0);
    @(negedge CLK);
    check_out("rstmid_producer", NormI);
    cycle(1, 9, 2'b01, 0, 0, 0, 1);
    @(negedge CLK);
    check_out("rstmid_flush", Flush);
    cycle(1, 9, 2'b01, 0, 0, 0, 0);
    RST = 1'b1;
    @(negedge CLK);
    check_out("rstmid_outputs", RstO);
    cycle(1, 9, 2'b01, 0, 0, 0, 0);
    RST = 1'b0;
    @(negedge CLK);
    check_out("rstmid_reader_issues", NormI);
    check_val("rstmid_stall_cnt", int'(stall_cnt), 0);
    check_val("rstmid_flush_cnt", int'(flush_cnt), 0);

    // Saturation on the 3-bit counter instance: 12 stalls, then 10 flushes
    for (int n = 0; n < 3; n++) begin
      cycle(1, 0, 2'b00, 12, 1, 4, 0);
      for (int s = 0; s < 5; s++) cycle(1, 12, 2'b01, 0, 0, 0, 0);
    end
    cycle(0, 0, 2'b00, 0, 0, 0, 0);
    @(negedge CLK);
    check_val("sat_stall_main", int'(stall_cnt), 12);
    check_val("sat_stall_narrow", int'(stall_cnt_s), 7);
    for (int f = 0; f < 10; f++) cycle(0, 0, 2'b00, 0, 0, 0, 1);
    cycle(0, 0, 2'b00, 0, 0, 0, 0);
    @(negedge CLK);
    check_val("sat_flush_main", int'(flush_cnt), 10);
    check_val("sat_flush_narrow", int'(flush_cnt_s), 7);
    check_val("sat_stall_narrow_hold", int'(stall_cnt_s), 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the pipeline hazard unit. It tracks pending register writes with per-register latency countdowns, so it stalls dependent instructions for variable-latency producers: loads, multi-cycle ALU ops, and so on.
- Flush after a PC redirect lasts a configurable number of cycles.
- The whole pipeline freezes while data memory is busy.
- Sits beside the decode stage. It drives PC, IF/ID and ID/EX control, and keeps stall and flush performance counters.

Parameters:
- REG_ADDR_W, 5, register index width; the register file holds 2**REG_ADDR_W entries.
- NUM_RD, 2, number of source operands checked per instruction.
- MAX_LAT, 4, maximum producer latency in cycles; must be at least 1.
- CNT_W, 3, scoreboard counter width; must satisfy 2**CNT_W-1 >= MAX_LAT.
- FLUSH_DEPTH, 1, number of cycles that flushed is held after a redirect; must be at least 1.
- PERF_W, 16, width of each performance counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- id_valid  in  1  the decode stage holds a real instruction.
- id_rsel  in  NUM_RD*REG_ADDR_W  source register indices; operand i occupies bits [i*REG_ADDR_W +: REG_ADDR_W].
- id_ruse  in  NUM_RD  per-operand "operand actually read" flag.
- id_wsel  in  REG_ADDR_W  destination register index.
- id_wen  in  1  the instruction writes id_wsel.
- id_lat  in  CNT_W  cycles before the result is forwardable; 0 means no stall needed.
- pc_src  in  2  PC select from execute: 0 = PC4, 1 = BRANCH, 2 = JUMP, 3 = JR.
- dmem_busy  in  1  the memory stage is waiting on data memory.
- pc_en  out  1  PC register load enable.
- id_en  out  1  IF/ID register enable.
- flushed  out  1  clear IF/ID to a bubble.
- ex_bubble  out  1  insert a bubble into ID/EX.
- issue  out  1  the decode instruction advances this cycle.
- stall_cnt  out  PERF_W  count of data-stall cycles.
- flush_cnt  out  PERF_W  count of flush cycles.

Behaviour:
- State:
  - sb_cnt[r], CNT_W bits, one per register.
  - fl_cnt, range 0..FLUSH_DEPTH-1.
  - Two performance counters.
- Reset: when RST is high at a clock edge, all counters clear to 0. Combinationally, while RST is high:
  - pc_en=0, id_en=0, issue=0.
  - flushed=1, ex_bubble=1.
- Derived terms:
  - freeze = dmem_busy.
  - redirect = (pc_src != 0).
  - flush_act = redirect or (fl_cnt != 0).
  - dstall = id_valid and, for some operand i, id_ruse[i] and id_rsel[i] != 0 and sb_cnt[id_rsel[i]] != 0.
- Priority, evaluated combinationally: freeze, then flush_act, then dstall, then normal.
  - freeze: pc_en=0, id_en=0, flushed=0, ex_bubble=0, issue=0. All state holds: sb_cnt, fl_cnt and the performance counters. A redirect asserted during freeze is acted on in the first non-frozen cycle.
  - flush_act: pc_en=1 (redirect target or next fetch loads), id_en=1, flushed=1, ex_bubble=1, issue=0.
    - If redirect, fl_cnt <= FLUSH_DEPTH-1; otherwise fl_cnt decrements.
    - A redirect arriving while fl_cnt != 0 reloads fl_cnt.
    - flush_cnt increments.
  - dstall: pc_en=0, id_en=0, flushed=0, ex_bubble=1, issue=0. stall_cnt increments.
  - normal: pc_en=1, id_en=1, flushed=0, ex_bubble=0, issue=id_valid.
- Scoreboard update on every non-frozen edge:
  - Every nonzero sb_cnt decrements by 1.
  - Then, if issue and id_wen and id_wsel != 0, sb_cnt[id_wsel] <= min(id_lat, MAX_LAT). The issue write overrides the decrement of the same entry.
  - Register 0 is never pending; its entry stays 0.
- Latency rule: a producer with id_lat=L followed directly by a dependent stalls the dependent exactly L cycles, excluding freeze cycles. For example, a load with L=1 gives one bubble, matching the load-use case.
- A squashed decode instruction (flush_act) never sets the scoreboard.
- A stall on one operand with id_ruse=0 is not a hazard, and neither is a match only on register 0.
- Performance counters saturate at all-ones and do not wrap.
- Timing: outputs are purely combinational from state and inputs; the block adds no extra latency.
- Mid-operation reset: clears all pending entries and the flush window immediately at that edge.

Test Plan:
- Load-use: issue a write to r5 with lat=1, then the next instruction reads r5 (id_ruse=01) -> exactly 1 cycle of pc_en=0, id_en=0, ex_bubble=1; issue=1 on the following cycle; stall_cnt=1.
- Long latency with freeze: lat=3 producer to r7; dependent follows; dmem_busy=1 for 2 cycles in the middle -> 3 stall cycles plus 2 frozen cycles; sb_cnt[7] holds during freeze; stall_cnt=3.
- Register 0 and unused operand: producer writes r0 with lat=4, dependent reads r0; then producer to r3 with lat=2, dependent has id_rsel[1]=3 and id_ruse=01 -> no stalls in either case.
- Redirect with FLUSH_DEPTH=2: pc_src=2 for one cycle -> flushed=1 and ex_bubble=1 for 2 cycles, pc_en=1; a second pc_src=3 in cycle 2 extends the flush to 3 cycles total; flush_cnt=3.
- Redirect versus data stall: pc_src=1 coinciding with dstall -> flush wins (flushed=1, pc_en=1); the squashed instruction does not write sb_cnt.
- Reset mid-stall: RST=1 while sb_cnt[9]=3 and a flush is active -> next cycle all counters are 0; while RST is high, outputs are pc_en=0, flushed=1; after release, a reader of r9 issues without stalling.
